// File: rtl/atm_pkg.sv
// atm_pkg - types and constants shared between the ATM main FSM and the
// PIN-entry verifier: verifier state enumeration, attempt-limit default,
// BCD range and the controller opcode set.
package atm_pkg;

    // Verifier states.
    typedef enum logic [2:0] {
        PV_IDLE    = 3'd0,
        PV_COLLECT = 3'd1,
        PV_COMPARE = 3'd2,
        PV_PASS    = 3'd3,
        PV_FAIL    = 3'd4,
        PV_LOCKED  = 3'd5
    } pin_state_t;

    // Failed attempts allowed before the card is retained.
    localparam int MAX_TRIES_DEFAULT = 3;

    // Largest legal keypad digit.
    localparam int unsigned BCD_MAX = 9;

    // Opcodes exchanged with the ATM main FSM.
    localparam logic [2:0] OP_NONE       = 3'd0;
    localparam logic [2:0] OP_BALANCE    = 3'd1;
    localparam logic [2:0] OP_WITHDRAW   = 3'd2;
    localparam logic [2:0] OP_DEPOSIT    = 3'd3;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
    localparam logic [2:0] OP_EXIT       = 3'd5;

    // True when a keypad code is a decimal digit.
    function automatic logic is_bcd(input int unsigned code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/atm_entry_timer.sv
// atm_entry_timer - loadable down-counter measuring idle time between
// keypad digits. Holds its load value while disabled, reloads on restart,
// and flags terminal count while enabled and at zero.
module atm_entry_timer #(
    parameter int TIMEOUT_CYC = 1000,
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic term
);

    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Count down while enabled; reload whenever idle time must start over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= LOAD;
        end else if (!en || restart) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign term = en && (cnt == '0);

endmodule

// File: rtl/atm_pin_verifier.sv
// atm_pin_verifier - PIN-entry responder for the ATM controller.
// Shifts keypad digits into an entry register, compares against the card's
// stored PIN, reports pass/fail, counts failed attempts and locks the card
// once they are exhausted.
// Optional build macro: PIN_TIMEOUT_EN adds an inter-digit idle timeout
// that counts as a failed attempt; without it, timeout is tied low.
module atm_pin_verifier
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = MAX_TRIES_DEFAULT,
    parameter int TIMEOUT_CYC = 1000,
    localparam int PIN_W = PIN_DIGITS * DIGIT_W,
    localparam int TRY_W = $clog2(MAX_TRIES + 1),
    localparam int CNT_W = $clog2(PIN_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_in,
    input  logic             start,
    input  logic             digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic             clear_entry,
    input  logic             admin_unlock,
    input  logic [PIN_W-1:0] stored_pin,
    output logic             correct_password,
    output logic             pin_fail,
    output logic             card_lock,
    output logic             busy,
    output logic [TRY_W-1:0] tries_left,
    output logic [CNT_W-1:0] digits_entered,
    output logic             timeout
);

    pin_state_t       state;
    logic [PIN_W-1:0] entry;
    logic             timeout_q;
    logic             digit_ok;
    logic             entry_full;
    logic             timer_term;

    assign digit_ok   = digit_valid && is_bcd(32'(digit));
    assign entry_full = (digits_entered == CNT_W'(PIN_DIGITS));
    assign timeout    = timeout_q;

`ifdef PIN_TIMEOUT_EN
    logic timer_en;
    logic timer_restart;

    // Idle time counts only while collecting; any accepted digit or a clear
    // gives the customer a fresh window.
    assign timer_en      = (state == PV_COLLECT);
    assign timer_restart = clear_entry || (digit_ok && !entry_full);

    atm_entry_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_entry_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (timer_en),
        .restart (timer_restart),
        .term    (timer_term)
    );
`else
    assign timer_term = 1'b0;
`endif

    // Verifier FSM with all outputs registered alongside the state.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= PV_IDLE;
            // NOTE: the entry register is reset like any other flop because
            // a stale PIN must never survive a reset.
            entry            <= '0;
            digits_entered   <= '0;
            tries_left       <= TRY_W'(MAX_TRIES);
            correct_password <= 1'b0;
            pin_fail         <= 1'b0;
            card_lock        <= 1'b0;
            busy             <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            // Pulse outputs default low; a transition below may raise them.
            pin_fail  <= 1'b0;
            timeout_q <= 1'b0;

            case (state)
                PV_IDLE: begin
                    if (start && card_in) begin
                        state          <= PV_COLLECT;
                        entry          <= '0;
                        digits_entered <= '0;
                        busy           <= 1'b1;
                    end
                end

                PV_COLLECT: begin
                    if (!card_in) begin
                        // Card pulled: abandon entry, keep the attempt count.
                        state          <= PV_IDLE;
                        entry          <= '0;
                        digits_entered <= '0;
                        busy           <= 1'b0;
                    end else if (clear_entry) begin
                        // Clear beats a simultaneous digit and is not an attempt.
                        entry          <= '0;
                        digits_entered <= '0;
                    end else if (entry_full) begin
                        state <= PV_COMPARE;
                    end else if (digit_ok) begin
                        entry          <= {entry[PIN_W-DIGIT_W-1:0], digit};
                        digits_entered <= digits_entered + CNT_W'(1);
                    end else if (timer_term) begin
                        // Idle too long: treated exactly like a wrong PIN.
                        state      <= PV_FAIL;
                        timeout_q  <= 1'b1;
                        pin_fail   <= 1'b1;
                        tries_left <= tries_left - TRY_W'(1);
                        busy       <= 1'b0;
                    end
                end

                PV_COMPARE: begin
                    if (!card_in) begin
                        state          <= PV_IDLE;
                        entry          <= '0;
                        digits_entered <= '0;
                        busy           <= 1'b0;
                    end else if (entry == stored_pin) begin
                        // Full-width compare, no early exit on first mismatch.
                        state            <= PV_PASS;
                        correct_password <= 1'b1;
                        tries_left       <= TRY_W'(MAX_TRIES);
                        busy             <= 1'b0;
                    end else begin
                        state      <= PV_FAIL;
                        pin_fail   <= 1'b1;
                        tries_left <= tries_left - TRY_W'(1);
                        busy       <= 1'b0;
                    end
                end

                PV_PASS: begin
                    if (!card_in) begin
                        state            <= PV_IDLE;
                        correct_password <= 1'b0;
                        entry            <= '0;
                        digits_entered   <= '0;
                    end
                end

                PV_FAIL: begin
                    // Single-cycle state; the next attempt always starts empty.
                    entry          <= '0;
                    digits_entered <= '0;
                    if (!card_in) begin
                        state <= PV_IDLE;
                    end else if (tries_left == '0) begin
                        state     <= PV_LOCKED;
                        card_lock <= 1'b1;
                    end else begin
                        state <= PV_COLLECT;
                        busy  <= 1'b1;
                    end
                end

                PV_LOCKED: begin
                    // Card stays retained even if card_in drops.
                    if (admin_unlock) begin
                        state      <= PV_IDLE;
                        card_lock  <= 1'b0;
                        tries_left <= TRY_W'(MAX_TRIES);
                    end
                end

                default: begin
                    state <= PV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_pin_verifier.sv
// tb_atm_pin_verifier - self-checking bench for atm_pin_verifier.
// Table-driven directed vectors, hand-written corner sequences, then
// randomized stimulus against a queue-based reference model.
// Timeout cases run only when PIN_TIMEOUT_EN is defined.
module tb_atm_pin_verifier;

    localparam int PIN_DIGITS  = 4;
    localparam int DIGIT_W     = 4;
    localparam int MAX_TRIES   = 3;
    localparam int TIMEOUT_CYC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        card_in = 1'b0;
    logic        start = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        clear_entry = 1'b0;
    logic        admin_unlock = 1'b0;
    logic [15:0] stored_pin = 16'h1234;
    logic        correct_password;
    logic        pin_fail;
    logic        card_lock;
    logic        busy;
    logic [1:0]  tries_left;
    logic [2:0]  digits_entered;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int pf_seen = 0;

    always #5 clk = ~clk;

    atm_pin_verifier #(
        .PIN_DIGITS  (PIN_DIGITS),
        .DIGIT_W     (DIGIT_W),
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .card_in          (card_in),
        .start            (start),
        .digit_valid      (digit_valid),
        .digit            (digit),
        .clear_entry      (clear_entry),
        .admin_unlock     (admin_unlock),
        .stored_pin       (stored_pin),
        .correct_password (correct_password),
        .pin_fail         (pin_fail),
        .card_lock        (card_lock),
        .busy             (busy),
        .tries_left       (tries_left),
        .digits_entered   (digits_entered),
        .timeout          (timeout)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic c, input logic f, input logic l,
                              input logic b, input int t, input int d, input logic to);
        logic [15:0] act;
        logic [15:0] exp;
        act = {correct_password, pin_fail, card_lock, busy, 4'(tries_left), 4'(digits_entered), timeout, 3'b0};
        exp = {c, f, l, b, 4'(t), 4'(d), to, 3'b0};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got corr=%b fail=%b lock=%b busy=%b tries=%0d digits=%0d to=%b; want corr=%b fail=%b lock=%b busy=%b tries=%0d digits=%0d to=%b",
                     name, correct_password, pin_fail, card_lock, busy, tries_left, digits_entered, timeout,
                     c, f, l, b, t, d, to);
        end
    endtask

    task automatic drive(input logic ci, input logic st, input logic dv, input logic [3:0] dg,
                         input logic clr, input logic adm);
        card_in      = ci;
        start        = st;
        digit_valid  = dv;
        digit        = dg;
        clear_entry  = clr;
        admin_unlock = adm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pin_fail) pf_seen++;
    endtask

    task automatic type_digit(input logic [3:0] dg);
        drive(1'b1, 1'b0, 1'b1, dg, 1'b0, 1'b0);
        tick();
    endtask

    task automatic idle_cycle();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       card, st, dv;
        logic [3:0] dg;
        logic       clr, adm;
        logic       corr, fail, lock, bsy;
        int         tries, digits;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int card, input int st, input int dv, input int dg,
                                input int clr, input int adm, input int corr, input int fail,
                                input int lock, input int bsy, input int tries, input int digits);
        vec_t r;
        r.card = (card != 0); r.st = (st != 0); r.dv = (dv != 0); r.dg = 4'(dg);
        r.clr = (clr != 0); r.adm = (adm != 0);
        r.corr = (corr != 0); r.fail = (fail != 0); r.lock = (lock != 0); r.bsy = (bsy != 0);
        r.tries = tries; r.digits = digits;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ENTRY, M_CHECK, M_OK, M_BAD, M_LOCK} mmode_t;
    mmode_t m_mode;
    int     m_q[$];
    int     m_tries;
    int     m_idle;
    logic   m_to;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_tries = MAX_TRIES;
        m_idle = 0;
        m_to = 1'b0;
    endtask

    function automatic bit pin_matches();
        if (m_q.size() != PIN_DIGITS) return 1'b0;
        for (int i = 0; i < PIN_DIGITS; i++)
            if (m_q[i] != int'(stored_pin[(PIN_DIGITS-1-i)*4 +: 4])) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model by one clock given the inputs seen at that edge.
    task automatic model_step(input logic ci, input logic st, input logic dv, input logic [3:0] dg,
                              input logic clr, input logic adm);
        m_to = 1'b0;
        case (m_mode)
            M_IDLE: if (st && ci) begin m_mode = M_ENTRY; m_q.delete(); m_idle = 0; end
            M_ENTRY: begin
                if (!ci) begin m_mode = M_IDLE; m_q.delete(); end
                else if (clr) begin m_q.delete(); m_idle = 0; end
                else if (m_q.size() == PIN_DIGITS) m_mode = M_CHECK;
                else if (dv && dg <= 4'd9) begin m_q.push_back(int'(dg)); m_idle = 0; end
                else begin
`ifdef PIN_TIMEOUT_EN
                    if (m_idle == TIMEOUT_CYC - 1) begin
                        m_mode = M_BAD; m_tries--; m_to = 1'b1;
                    end else m_idle++;
`endif
                end
            end
            M_CHECK: begin
                if (!ci) begin m_mode = M_IDLE; m_q.delete(); end
                else if (pin_matches()) begin m_mode = M_OK; m_tries = MAX_TRIES; end
                else begin m_mode = M_BAD; m_tries--; end
            end
            M_OK: if (!ci) begin m_mode = M_IDLE; m_q.delete(); end
            M_BAD: begin
                m_q.delete();
                if (!ci) m_mode = M_IDLE;
                else if (m_tries == 0) m_mode = M_LOCK;
                else begin m_mode = M_ENTRY; m_idle = 0; end
            end
            M_LOCK: if (adm) begin m_mode = M_IDLE; m_tries = MAX_TRIES; end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [15:0] rand_pin();
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < PIN_DIGITS; i++) p = {p[11:0], 4'($urandom_range(0, 9))};
        return p;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        int bad_pin[4];
        int tb_tries;
        int to_at;
        logic ci, st, dv, clr, adm;
        logic [3:0] dg;
        int r;

        bad_pin = '{1, 2, 3, 5};

        // Plan: pass 1234, three failed attempts to lock, admin unlock.
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,1,3,0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(1,0,1,i,0,0, 0,0,0,1,3,i));
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,1,3,4));   // compare cycle
        tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,3,4));   // pass, two edges after 4th digit
        tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,3,4));   // pass held
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,3,0));   // card out -> idle
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,1,3,0));
        for (int a = 0; a < MAX_TRIES; a++) begin
            tb_tries = MAX_TRIES - a;
            for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,1,bad_pin[i],0,0, 0,0,0,1,tb_tries,i+1));
            tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,1,tb_tries,4));
            tbl.push_back(mk(1,0,0,0,0,0, 0,1,0,0,tb_tries-1,4));
            if (tb_tries - 1 > 0) tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,1,tb_tries-1,0));
            else                  tbl.push_back(mk(1,0,0,0,0,0, 0,0,1,0,0,0));
        end
        tbl.push_back(mk(1,1,1,1,0,0, 0,0,1,0,0,0));   // start/digit ignored when locked
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0));   // card out does not unlock
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,3,0));   // admin unlock

        // Reset values.
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #12;
        check_outs("reset_values", 0,0,0,0,3,0,0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].card, tbl[i].st, tbl[i].dv, tbl[i].dg, tbl[i].clr, tbl[i].adm);
            tick();
            check_outs($sformatf("table[%0d]", i), tbl[i].corr, tbl[i].fail, tbl[i].lock,
                       tbl[i].bsy, tbl[i].tries, tbl[i].digits, 1'b0);
        end

        // Clear together with a digit: clear wins, no attempt consumed.
        pf_seen = 0;
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0); tick();
        type_digit(4'd1); type_digit(4'd2);
        drive(1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0); tick();
        check_outs("clear_wins", 0,0,0,1,3,0,0);
        type_digit(4'd1); type_digit(4'd2); type_digit(4'd3); type_digit(4'd4);
        idle_cycle(); idle_cycle();
        check_outs("clear_then_pass", 1,0,0,0,3,4,0);
        check("clear_no_pin_fail", 32'(pf_seen), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); tick();

        // Non-BCD digit mid-entry is ignored.
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0); tick();
        type_digit(4'd1); type_digit(4'd2);
        type_digit(4'hB);
        check_outs("non_bcd_ignored", 0,0,0,1,3,2,0);
        type_digit(4'd3); type_digit(4'd4);
        idle_cycle(); idle_cycle();
        check_outs("non_bcd_then_pass", 1,0,0,0,3,4,0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); tick();

        // Card removed mid-entry keeps the reduced attempt count.
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 4; i++) type_digit(4'd7);
        idle_cycle(); idle_cycle(); idle_cycle();
        check_outs("retry_after_fail", 0,0,0,1,2,0,0);
        type_digit(4'd1); type_digit(4'd2);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); tick();
        check_outs("card_out_abort", 0,0,0,0,2,0,0);

        // Asynchronous reset while comparing.
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0); tick();
        type_digit(4'd1); type_digit(4'd2); type_digit(4'd3); type_digit(4'd4);
        idle_cycle();
        check_outs("in_compare", 0,0,0,1,2,4,0);
        reset = 1'b0;
        #2;
        check_outs("async_reset", 0,0,0,0,3,0,0);
        #2;
        reset = 1'b1;
        tick();
        check_outs("after_reset_idle", 0,0,0,0,3,0,0);

`ifdef PIN_TIMEOUT_EN
        // One digit then idle until timeout; must fire on the 8th idle edge.
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0); tick();
        type_digit(4'd1);
        to_at = -1;
        for (int i = 1; i <= 20 && to_at < 0; i++) begin
            idle_cycle();
            if (timeout) to_at = i;
        end
        check("timeout_cycle", 32'(to_at), 32'(TIMEOUT_CYC));
        check_outs("timeout_outputs", 0,1,0,0,2,1,1);
        idle_cycle();
        check_outs("timeout_back_collect", 0,0,0,1,2,0,0);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) idle_cycle();
        type_digit(4'd5);
        check_outs("digit_on_terminal", 0,0,0,1,2,1,0);
        idle_cycle();
        check_outs("no_late_timeout", 0,0,0,1,2,1,0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); tick();
`else
        to_at = 0;
        check("timeout_tied_low", 32'(timeout), 32'd0);
`endif

        // Randomized run against the reference model.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #4;
        reset = 1'b1;
        model_reset();
        stored_pin = rand_pin();
        for (int n = 0; n < 3000; n++) begin
            if (m_mode == M_IDLE && $urandom_range(0, 19) == 0) stored_pin = rand_pin();
            ci  = ($urandom_range(0, 99) >= 2);
            st  = ($urandom_range(0, 99) < 15);
            adm = ($urandom_range(0, 99) < 10);
            clr = ($urandom_range(0, 99) < 3);
            dv  = ($urandom_range(0, 99) < 60);
            r   = $urandom_range(0, 99);
            if (r < 75 && m_q.size() < PIN_DIGITS) dg = stored_pin[(PIN_DIGITS-1-m_q.size())*4 +: 4];
            else if (r < 85) dg = 4'($urandom_range(10, 15));
            else dg = 4'($urandom_range(0, 9));
            model_step(ci, st, dv, dg, clr, adm);
            drive(ci, st, dv, dg, clr, adm);
            tick();
            check_outs($sformatf("random[%0d]", n), m_mode == M_OK, m_mode == M_BAD,
                       m_mode == M_LOCK, (m_mode == M_ENTRY) || (m_mode == M_CHECK),
                       m_tries, m_q.size(), m_to);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
